// File: rtl/sram_dump_ctr.sv
// SRAM readback engine: fetches a programmed word range from SRAM and streams
// it out little-endian, one byte per valid/ready handshake.
module sram_dump_ctr #(
  parameter int DATA_W      = 32,
  parameter int SRAM_ADDR_W = 14,
  parameter int LEN_W       = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_valid,
  input  logic [1:0]             cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic [3:0]             cpu_wstrb,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ready,
  output logic                   sram_valid,
  output logic [SRAM_ADDR_W-3:0] sram_addr,
  input  logic [DATA_W-1:0]      sram_rdata,
  input  logic                   sram_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready
);

  localparam int WA_W = SRAM_ADDR_W - 2;

  localparam logic [1:0] REG_START  = 2'd0;
  localparam logic [1:0] REG_LEN    = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t            state_r, state_nx;
  logic [WA_W-1:0]   start_r, start_nx;
  logic [LEN_W-1:0]  len_r, len_nx;
  logic [WA_W-1:0]   addr_r, addr_nx;
  logic [DATA_W-1:0] word_r, word_nx;
  logic [1:0]        byte_cnt_r, byte_cnt_nx;
  logic [LEN_W-1:0]  word_cnt_r, word_cnt_nx;
  logic              done_r, done_nx;
  logic              abort_pend_r, abort_pend_nx;

  logic [DATA_W-1:0] cpu_rdata_r, cpu_rdata_nx;
  logic              cpu_ready_r, cpu_ready_nx;
  logic              sram_valid_r, sram_valid_nx;
  logic [WA_W-1:0]   sram_addr_r, sram_addr_nx;
  logic              tx_valid_r, tx_valid_nx;
  logic [7:0]        tx_data_r, tx_data_nx;

  logic              cpu_wr_s, busy_s, ctrl_wr_s;
  logic              start_cmd_s, abort_cmd_s, abort_eff_s;
  logic              sram_hs_s, tx_hs_s, last_byte_s;
  logic [LEN_W-1:0]  word_cnt_inc_s;
  logic              unused_s;

  // Only the SRAM-addressable part of the write data is ever stored.
  assign unused_s = ^cpu_wdata[DATA_W-1:SRAM_ADDR_W];

  // Command and handshake decode shared by all next-state logic.
  always_comb begin
    cpu_wr_s       = cpu_valid & (|cpu_wstrb);
    busy_s         = (state_r != ST_IDLE);
    ctrl_wr_s      = cpu_wr_s & (cpu_addr == REG_CTRL);
    start_cmd_s    = ctrl_wr_s & cpu_wdata[0] & ~cpu_wdata[1] & ~busy_s;
    abort_cmd_s    = ctrl_wr_s & cpu_wdata[1] & busy_s;
    abort_eff_s    = abort_pend_r | abort_cmd_s;
    sram_hs_s      = (state_r == ST_REQ) & sram_ready;
    tx_hs_s        = (state_r == ST_SEND) & tx_ready;
    last_byte_s    = tx_hs_s & (byte_cnt_r == 2'd3);
    word_cnt_inc_s = word_cnt_r + LEN_W'(1'b1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_cmd_s && (len_r != {LEN_W{1'b0}})) begin
          state_nx = ST_REQ;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (sram_ready) begin
          state_nx = abort_eff_s ? ST_IDLE : ST_SEND;
        end else begin
          state_nx = ST_REQ;
        end
      end
      ST_SEND: begin
        if (!tx_ready) begin
          state_nx = ST_SEND;
        end else if (abort_eff_s) begin
          state_nx = ST_IDLE;
        end else if (byte_cnt_r == 2'd3) begin
          state_nx = (word_cnt_inc_s == len_r) ? ST_IDLE : ST_REQ;
        end else begin
          state_nx = ST_SEND;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Register file and transfer datapath next values.
  always_comb begin
    start_nx      = start_r;
    len_nx        = len_r;
    addr_nx       = addr_r;
    word_nx       = word_r;
    byte_cnt_nx   = byte_cnt_r;
    word_cnt_nx   = word_cnt_r;
    done_nx       = done_r;
    abort_pend_nx = abort_pend_r;

    if (cpu_wr_s && !busy_s && (cpu_addr == REG_START)) begin
      start_nx = cpu_wdata[SRAM_ADDR_W-1:2];
    end else begin
      start_nx = start_r;
    end

    if (cpu_wr_s && !busy_s && (cpu_addr == REG_LEN)) begin
      len_nx = cpu_wdata[LEN_W-1:0];
    end else begin
      len_nx = len_r;
    end

    // Address wraps naturally at the top of SRAM.
    if (start_cmd_s) begin
      addr_nx = start_r;
    end else if (last_byte_s) begin
      addr_nx = addr_r + WA_W'(1'b1);
    end else begin
      addr_nx = addr_r;
    end

    if (sram_hs_s) begin
      word_nx = sram_rdata;
    end else begin
      word_nx = word_r;
    end

    if (sram_hs_s) begin
      byte_cnt_nx = 2'd0;
    end else if (tx_hs_s) begin
      byte_cnt_nx = byte_cnt_r + 2'd1;
    end else begin
      byte_cnt_nx = byte_cnt_r;
    end

    if (start_cmd_s) begin
      word_cnt_nx = {LEN_W{1'b0}};
    end else if (last_byte_s) begin
      word_cnt_nx = word_cnt_inc_s;
    end else begin
      word_cnt_nx = word_cnt_r;
    end

    if (start_cmd_s) begin
      done_nx = (len_r == {LEN_W{1'b0}});
    end else if (busy_s && (state_nx == ST_IDLE)) begin
      done_nx = 1'b1;
    end else begin
      done_nx = done_r;
    end

    if (state_nx == ST_IDLE) begin
      abort_pend_nx = 1'b0;
    end else if (abort_cmd_s) begin
      abort_pend_nx = 1'b1;
    end else begin
      abort_pend_nx = abort_pend_r;
    end
  end

  // Output next values, decoded from the upcoming state so outputs leave flops.
  always_comb begin
    cpu_ready_nx = cpu_valid;
    cpu_rdata_nx = {DATA_W{1'b0}};
    if (cpu_valid && !cpu_wr_s) begin
      case (cpu_addr)
        REG_START:  cpu_rdata_nx = {{(DATA_W-SRAM_ADDR_W){1'b0}}, start_r, 2'b00};
        REG_LEN:    cpu_rdata_nx = {{(DATA_W-LEN_W){1'b0}}, len_r};
        REG_CTRL:   cpu_rdata_nx = {DATA_W{1'b0}};
        REG_STATUS: cpu_rdata_nx = {{(DATA_W-LEN_W-2){1'b0}}, word_cnt_r, done_r, busy_s};
        default:    cpu_rdata_nx = {DATA_W{1'b0}};
      endcase
    end else begin
      cpu_rdata_nx = {DATA_W{1'b0}};
    end

    if (state_nx == ST_REQ) begin
      sram_valid_nx = 1'b1;
      sram_addr_nx  = addr_nx;
    end else begin
      sram_valid_nx = 1'b0;
      sram_addr_nx  = {WA_W{1'b0}};
    end

    if (state_nx == ST_SEND) begin
      tx_valid_nx = 1'b1;
      tx_data_nx  = pick_byte(word_nx, byte_cnt_nx);
    end else begin
      tx_valid_nx = 1'b0;
      tx_data_nx  = 8'h00;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_r      <= {WA_W{1'b0}};
      len_r        <= {LEN_W{1'b0}};
      addr_r       <= {WA_W{1'b0}};
      word_r       <= {DATA_W{1'b0}};
      byte_cnt_r   <= 2'd0;
      word_cnt_r   <= {LEN_W{1'b0}};
      done_r       <= 1'b0;
      abort_pend_r <= 1'b0;
      cpu_rdata_r  <= {DATA_W{1'b0}};
      cpu_ready_r  <= 1'b0;
      sram_valid_r <= 1'b0;
      sram_addr_r  <= {WA_W{1'b0}};
      tx_valid_r   <= 1'b0;
      tx_data_r    <= 8'h00;
    end else begin
      start_r      <= start_nx;
      len_r        <= len_nx;
      addr_r       <= addr_nx;
      word_r       <= word_nx;
      byte_cnt_r   <= byte_cnt_nx;
      word_cnt_r   <= word_cnt_nx;
      done_r       <= done_nx;
      abort_pend_r <= abort_pend_nx;
      cpu_rdata_r  <= cpu_rdata_nx;
      cpu_ready_r  <= cpu_ready_nx;
      sram_valid_r <= sram_valid_nx;
      sram_addr_r  <= sram_addr_nx;
      tx_valid_r   <= tx_valid_nx;
      tx_data_r    <= tx_data_nx;
    end
  end

  assign cpu_rdata  = cpu_rdata_r;
  assign cpu_ready  = cpu_ready_r;
  assign sram_valid = sram_valid_r;
  assign sram_addr  = sram_addr_r;
  assign tx_valid   = tx_valid_r;
  assign tx_data    = tx_data_r;

endmodule

// File: tb/tb_sram_dump_ctr.sv
// Directed bench for sram_dump_ctr: SRAM responder with one-cycle latency,
// byte/address monitors and register-level checks.
module tb_sram_dump_ctr;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid;
  logic [1:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        sram_valid;
  logic [11:0] sram_addr;
  logic [31:0] sram_rdata;
  logic        sram_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  sram_dump_ctr dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .sram_valid(sram_valid), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] mem [0:4095];
  logic [7:0]  txq[$];
  logic [11:0] aq[$];
  int act_cnt = 0;
  int viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int tx_mode = 0;
  int tx_base = 0;
  int stop_at = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: sample away from the active edge; a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (sram_valid && sram_ready) aq.push_back(sram_addr);
      if (sram_valid || tx_valid) act_cnt <= act_cnt + 1;
      if (prev_stall && !(tx_valid && tx_data == prev_data)) viol <= viol + 1;
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end
  end

  // SRAM responder: ready one cycle after a new request, single beat.
  initial begin
    logic pending;
    pending = 1'b0;
    sram_ready = 1'b0;
    sram_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        pending = 1'b0;
        sram_ready = 1'b0;
      end else if (pending) begin
        pending = 1'b0;
        sram_ready = 1'b1;
        sram_rdata = mem[sram_addr];
      end else begin
        sram_ready = 1'b0;
        if (sram_valid) pending = 1'b1;
      end
    end
  end

  // Downstream ready driver.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        0: tx_ready = 1'b0;
        1: tx_ready = 1'b1;
        2: tx_ready = 1'($urandom_range(0, 1));
        3: tx_ready = ((txq.size() - tx_base) < stop_at);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_wstrb = 4'hF;
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_wstrb = 4'h0; cpu_wdata = 32'h0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    cpu_valid = 1'b1; cpu_addr = a; cpu_wstrb = 4'h0;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    d = cpu_rdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    st = 32'h1;
    for (int i = 0; i < 500; i++) begin
      cpu_read(2'd3, st);
      if (!st[0]) break;
    end
    check_eq(tag, {31'h0, st[0]}, 32'h0);
  endtask

  task automatic check_stream(input string tag, input int base, input int n, input logic [63:0] exp);
    logic [31:0] got;
    check_eq({tag, "_count"}, txq.size() - base, n);
    for (int i = 0; i < n; i++) begin
      got = (base + i < txq.size()) ? {24'h0, txq[base + i]} : 32'hFFFF_FFFF;
      check_eq($sformatf("%s_b%0d", tag, i), got, {24'h0, exp[8*i +: 8]});
    end
  endtask

  initial begin
    logic [31:0] rd;
    int ab, act0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A5_0000 | i;
    mem[12'h040] = 32'h4433_2211;
    mem[12'h041] = 32'h8877_6655;
    mem[12'h042] = 32'hCCBB_AA99;
    mem[12'h043] = 32'h00FF_EEDD;
    mem[12'hFFF] = 32'hDDCC_BBAA;
    mem[12'h000] = 32'h0403_0201;
    rst = 1'b1; cpu_valid = 1'b0; cpu_addr = 2'd0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sram_valid", {31'h0, sram_valid}, 32'h0);
    check_eq("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check_eq("rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
    rst = 1'b0;
    cpu_read(2'd3, rd);
    check_eq("rst_status", rd, 32'h0);
    check_eq("rd_ready", {31'h0, cpu_ready}, 32'h1);
    @(posedge clk); #1;
    check_eq("rdata_idle_zero", cpu_rdata, 32'h0);
    check_eq("ready_one_cycle", {31'h0, cpu_ready}, 32'h0);

    // Basic two-word dump, truncating register writes.
    tx_mode = 1;
    cpu_write(2'd0, 32'hFFFF_C103);
    cpu_write(2'd1, 32'hFFFF_E002);
    cpu_read(2'd0, rd); check_eq("start_rb", rd, 32'h100);
    cpu_read(2'd1, rd); check_eq("len_rb", rd, 32'h2);
    cpu_read(2'd2, rd); check_eq("ctrl_rb", rd, 32'h0);
    tx_base = txq.size(); ab = aq.size();
    cpu_write(2'd2, 32'h1);
    wait_idle("basic_idle");
    check_stream("basic", tx_base, 8, 64'h8877_6655_4433_2211);
    check_eq("basic_naddr", aq.size() - ab, 2);
    if (aq.size() - ab == 2) begin
      check_eq("basic_a0", {20'h0, aq[ab]}, 32'h40);
      check_eq("basic_a1", {20'h0, aq[ab + 1]}, 32'h41);
    end
    cpu_read(2'd3, rd); check_eq("basic_status", rd, 32'h0A);

    // Same transfer with random back-pressure.
    tx_mode = 2;
    tx_base = txq.size();
    cpu_write(2'd2, 32'h1);
    wait_idle("rand_idle");
    tx_mode = 1;
    check_stream("rand", tx_base, 8, 64'h8877_6655_4433_2211);
    cpu_read(2'd3, rd); check_eq("rand_status", rd, 32'h0A);

    // Wrap at the top of SRAM.
    cpu_write(2'd0, 32'h0000_3FFC);
    tx_base = txq.size(); ab = aq.size();
    cpu_write(2'd2, 32'h1);
    wait_idle("wrap_idle");
    check_stream("wrap", tx_base, 8, 64'h0403_0201_DDCC_BBAA);
    check_eq("wrap_naddr", aq.size() - ab, 2);
    if (aq.size() - ab == 2) begin
      check_eq("wrap_a0", {20'h0, aq[ab]}, 32'hFFF);
      check_eq("wrap_a1", {20'h0, aq[ab + 1]}, 32'h0);
    end

    // LEN=0 completes immediately without any traffic.
    cpu_write(2'd1, 32'h0);
    act0 = act_cnt;
    cpu_write(2'd2, 32'h1);
    cpu_read(2'd3, rd); check_eq("len0_status", rd, 32'h02);
    repeat (10) @(posedge clk);
    #1;
    check_eq("len0_activity", act_cnt - act0, 32'h0);

    // Start and register writes while busy are ignored.
    tx_mode = 0;
    cpu_write(2'd0, 32'h100);
    cpu_write(2'd1, 32'h1);
    tx_base = txq.size();
    cpu_write(2'd2, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    cpu_write(2'd0, 32'h200);
    cpu_write(2'd1, 32'h3);
    cpu_write(2'd2, 32'h1);
    cpu_read(2'd0, rd); check_eq("busy_start_rb", rd, 32'h100);
    cpu_read(2'd1, rd); check_eq("busy_len_rb", rd, 32'h1);
    cpu_read(2'd3, rd); check_eq("busy_status", rd, 32'h01);
    tx_mode = 1;
    wait_idle("busy_idle");
    check_stream("busy", tx_base, 4, 64'h0000_0000_4433_2211);
    cpu_read(2'd3, rd); check_eq("busy_done_status", rd, 32'h06);

    // Abort during byte 1 of the second word.
    cpu_write(2'd1, 32'h4);
    tx_base = txq.size(); stop_at = 5; tx_mode = 3;
    cpu_write(2'd2, 32'h1);
    for (int i = 0; i < 200; i++) begin
      if ((txq.size() - tx_base) == 5 && tx_valid && !tx_ready) break;
      @(posedge clk); #2;
    end
    check_eq("abort_sync", {24'h0, tx_data}, 32'h66);
    cpu_write(2'd2, 32'h2);
    tx_mode = 1;
    wait_idle("abort_idle");
    repeat (10) @(posedge clk);
    #1;
    check_stream("abort", tx_base, 6, 64'h0000_6655_4433_2211);
    cpu_read(2'd3, rd); check_eq("abort_status", rd, 32'h06);

    // Reset while stalled in SEND.
    tx_mode = 0;
    cpu_write(2'd1, 32'h2);
    cpu_write(2'd2, 32'h1);
    for (int i = 0; i < 50; i++) begin
      if (tx_valid) break;
      @(posedge clk); #1;
    end
    check_eq("rs_sync", {31'h0, tx_valid}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rs_tx_valid", {31'h0, tx_valid}, 32'h0);
    check_eq("rs_sram_valid", {31'h0, sram_valid}, 32'h0);
    rst = 1'b0;
    act0 = act_cnt;
    tx_mode = 1;
    cpu_read(2'd3, rd); check_eq("rs_status", rd, 32'h0);
    cpu_read(2'd0, rd); check_eq("rs_start", rd, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("rs_activity", act_cnt - act0, 32'h0);

    check_eq("tx_stable", viol, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
